// File: rtl/spi_reg_bridge_pkg.sv
// spi_reg_bridge shared types and constants.
// State, width codes, header layout and width helpers.
package spi_reg_bridge_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_WDATA,
    S_TURN,
    S_RDATA,
    S_DONE
  } state_t;

  typedef enum logic [1:0] {
    W_BYTE = 2'b00,
    W_HALF = 2'b01,
    W_WORD = 2'b10,
    W_RSVD = 2'b11
  } width_t;

  localparam int RW_BIT    = 15;
  localparam int WIDTH_LSB = 8;
  localparam int ADDR_LSB  = 0;

  localparam logic [5:0] HDR_BITS  = 6'd16;
  localparam logic [5:0] TURN_BITS = 6'd8;

  // Number of data bits carried by a width code.
  function automatic logic [5:0] width_bits(
    input logic [1:0] w
  );
    logic [5:0] n;
    case (w)
      W_BYTE:  n = 6'd8;
      W_HALF:  n = 6'd16;
      W_WORD:  n = 6'd32;
      default: n = 6'd0;
    endcase
    return n;
  endfunction

  // Moves the active data bits to the top so MSB-first
  // shifting always starts from bit 31.
  function automatic logic [31:0] msb_align(
    input logic [1:0]  w,
    input logic [31:0] d
  );
    logic [31:0] r;
    case (w)
      W_BYTE:  r = {d[7:0], 24'b0};
      W_HALF:  r = {d[15:0], 16'b0};
      default: r = d;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/spi_reg_bridge_edge.sv
// spi_reg_bridge SPI clock edge detector.
// One register stage; rise/fall are single-clk pulses.
module spi_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic i_spi_clk,
  output logic o_rise,
  output logic o_fall
);

  logic r_prev;

  // Remember the previous spi_clk level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_prev <= 1'b0;
    else        r_prev <= i_spi_clk;
  end

  assign o_rise = i_spi_clk & ~r_prev;
  assign o_fall = ~i_spi_clk & r_prev;

endmodule

// File: rtl/spi_reg_bridge.sv
// spi_reg_bridge top: SPI mode-0 slave to register bus.
// Header, write data, turnaround and read data FSM.
module spi_reg_bridge
  import spi_reg_bridge_pkg::*;
#(
  parameter int ADDR_W = 6,
  parameter int REG_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              spi_cs_n,
  input  logic              spi_clk,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [REG_W-1:0]  reg_data_o,
  input  logic [REG_W-1:0]  reg_data_i,
  input  logic              reg_data_i_dv,
  output logic              reg_addr_v,
  output logic              reg_data_o_dv,
  output logic              reg_rw,
  output logic [1:0]        txn_width
);

  state_t           r_state;
  logic [5:0]       r_cnt;
  logic [REG_W-2:0] r_rx;
  logic [REG_W-1:0] r_tx;
  logic [REG_W-1:0] r_rdata;
  logic             r_have;
  logic             r_loaded;
  logic             r_cs_hi;

  logic             w_rise;
  logic             w_fall;
  logic [15:0]      w_hdr;
  logic [1:0]       w_hdr_w;
  logic [5:0]       w_last;
  logic [REG_W-1:0] w_load;
  logic             w_unused;

  spi_edge_det u_edge (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_spi_clk (spi_clk),
    .o_rise    (w_rise),
    .o_fall    (w_fall)
  );

  assign w_hdr    = {r_rx[14:0], spi_mosi};
  assign w_hdr_w  = w_hdr[WIDTH_LSB +: 2];
  assign w_last   = width_bits(txn_width) - 6'd1;
  assign w_load   = msb_align(txn_width,
                      r_have ? r_rdata : '0);
  assign w_unused = ^w_hdr;

  // Frame FSM with all bus outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_rx          <= '0;
      r_tx          <= '0;
      r_rdata       <= '0;
      r_have        <= 1'b0;
      r_loaded      <= 1'b0;
      r_cs_hi       <= 1'b0;
      spi_miso      <= 1'b0;
      reg_addr      <= '0;
      reg_data_o    <= '0;
      reg_addr_v    <= 1'b0;
      reg_data_o_dv <= 1'b0;
      reg_rw        <= 1'b0;
      txn_width     <= 2'b00;
    end else begin
      reg_data_o_dv <= 1'b0;
      if (reg_addr_v && reg_data_i_dv) begin
        reg_addr_v <= 1'b0;
        r_rdata    <= reg_data_i;
        r_have     <= 1'b1;
      end
      if (spi_cs_n) begin
        r_state    <= S_IDLE;
        r_cs_hi    <= 1'b1;
        reg_addr_v <= 1'b0;
        spi_miso   <= 1'b0;
      end else begin
        unique case (r_state)
          S_IDLE: begin
            if (r_cs_hi) begin
              r_state <= S_HDR;
              r_cnt   <= '0;
              r_cs_hi <= 1'b0;
            end
          end
          S_HDR: begin
            if (w_rise) begin
              r_rx  <= {r_rx[REG_W-3:0], spi_mosi};
              r_cnt <= r_cnt + 6'd1;
              if (r_cnt == HDR_BITS - 6'd1) begin
                r_cnt     <= '0;
                r_rx      <= '0;
                reg_addr  <= w_hdr[ADDR_LSB +: ADDR_W];
                reg_rw    <= w_hdr[RW_BIT];
                txn_width <= w_hdr_w;
                if (w_hdr_w == W_RSVD) begin
                  r_state <= S_DONE;
                end else if (w_hdr[RW_BIT]) begin
                  r_state <= S_WDATA;
                end else begin
                  r_state    <= S_TURN;
                  reg_addr_v <= 1'b1;
                  r_have     <= 1'b0;
                  r_loaded   <= 1'b0;
                end
              end
            end
          end
          S_WDATA: begin
            if (w_rise) begin
              r_rx  <= {r_rx[REG_W-3:0], spi_mosi};
              r_cnt <= r_cnt + 6'd1;
              if (r_cnt == w_last) begin
                reg_data_o    <= {r_rx, spi_mosi};
                reg_data_o_dv <= 1'b1;
                r_state       <= S_DONE;
              end
            end
          end
          S_TURN: begin
            if (w_rise) begin
              r_cnt <= r_cnt + 6'd1;
              if (r_cnt == TURN_BITS - 6'd1) begin
                r_cnt   <= '0;
                r_state <= S_RDATA;
              end
            end
          end
          S_RDATA: begin
            // The fall closing the turnaround loads the MSB.
            if (w_fall) begin
              if (!r_loaded) begin
                r_loaded <= 1'b1;
                spi_miso <= w_load[REG_W-1];
                r_tx     <= {w_load[REG_W-2:0], 1'b0};
              end else begin
                spi_miso <= r_tx[REG_W-1];
                r_tx     <= {r_tx[REG_W-2:0], 1'b0};
              end
            end
            if (w_rise) begin
              r_cnt <= r_cnt + 6'd1;
              if (r_cnt == w_last) begin
                r_state  <= S_DONE;
                spi_miso <= 1'b0;
              end
            end
          end
          S_DONE: begin
          end
          default: begin
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule
